// File: rtl/chunked_adder.sv
// rtl/chunked_adder.sv - multi-cycle add/subtract, CHUNK bits per clock with a registered carry
// Valid/ready on both sides; reports carry, signed overflow and zero for the completed sum.
module chunked_adder #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int IW     = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

   logic             accept, last_chunk, c_chunk;
   logic [IW-1:0]    base;
   logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;

   assign accept     = (state_q == S_IDLE) && in_valid;
   assign last_chunk = (cnt_q == CW'(NCHUNK - 1));
   assign base       = IW'(cnt_q) * IW'(CHUNK);
   assign a_chunk    = a_q[base +: CHUNK];
   assign b_chunk    = b_q[base +: CHUNK];
   assign {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = S_RUN;
         S_RUN:   if (last_chunk) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // b is stored already inverted for subtract, so RUN only ever adds.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      if (accept) begin
         a_d     = a;
         b_d     = sub ? ~b : b;
         carry_d = sub ? 1'b1 : cin;
         a_msb_d = a[WIDTH-1];
         b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
         cnt_d   = '0;
      end else if (state_q == S_RUN) begin
         sum_d[base +: CHUNK] = s_chunk;
         carry_d = c_chunk;
         cnt_d   = cnt_q + CW'(1);
         if (last_chunk) begin
            cout_d = c_chunk;
            ovf_d  = (a_msb_q == b_msb_q) && (sum_d[WIDTH-1] != a_msb_q);
            zero_d = (sum_d == '0);
         end
      end
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_chunked_adder.sv
// tb/tb_chunked_adder.sv - self-checking bench for chunked_adder
// Directed 8-bit cases plus a randomized 64-bit sweep over three chunk sizes.
module tb_chunked_adder;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   logic       iv8 = 1'b0, or8 = 1'b1, cin8 = 1'b0, sub8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       ir8, ov8, co8, of8, z8;
   logic [7:0] s8;

   chunked_adder #(.WIDTH(8), .CHUNK(4)) d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
      .cout(co8), .ovf(of8), .zero(z8));

   logic        iv64 = 1'b0, cin64 = 1'b0, sub64 = 1'b0;
   logic [63:0] a64 = '0, b64 = '0;
   logic        ir64 [3];
   logic        ovd64 [3];
   logic        co64 [3];
   logic        of64 [3];
   logic        z64 [3];
   logic [63:0] s64 [3];
   int          lat_exp [3] = '{1, 4, 64};

   chunked_adder #(.WIDTH(64), .CHUNK(64)) d64w (
      .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64[0]), .a(a64), .b(b64),
      .cin(cin64), .sub(sub64), .out_valid(ovd64[0]), .out_ready(1'b1), .sum(s64[0]),
      .cout(co64[0]), .ovf(of64[0]), .zero(z64[0]));
   chunked_adder #(.WIDTH(64), .CHUNK(16)) d64m (
      .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64[1]), .a(a64), .b(b64),
      .cin(cin64), .sub(sub64), .out_valid(ovd64[1]), .out_ready(1'b1), .sum(s64[1]),
      .cout(co64[1]), .ovf(of64[1]), .zero(z64[1]));
   chunked_adder #(.WIDTH(64), .CHUNK(1)) d64s (
      .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64[2]), .a(a64), .b(b64),
      .cin(cin64), .sub(sub64), .out_valid(ovd64[2]), .out_ready(1'b1), .sum(s64[2]),
      .cout(co64[2]), .ovf(of64[2]), .zero(z64[2]));

   // Reference: exact integer arithmetic on wide signed values, then reduce mod 2^w.
   function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input logic s, output logic [63:0] rs,
                                 output logic rc, output logic ro, output logic rz);
      logic signed [66:0] m, ua, ub, sa, sb, cc, ex, sx;
      m  = 67'sd1 <<< w;
      ua = {3'b000, a};
      ub = {3'b000, b};
      cc = {66'd0, c};
      sa = a[w-1] ? ua - m : ua;
      sb = b[w-1] ? ub - m : ub;
      if (s) begin
         ex = ua - ub;
         sx = sa - sb;
         rc = (ua >= ub);
      end else begin
         ex = ua + ub + cc;
         sx = sa + sb + cc;
         rc = (ex >= m);
      end
      rs = 64'(ex & (m - 67'sd1));
      ro = (sx >= (m >>> 1)) || (sx < -(m >>> 1));
      rz = (rs == 64'd0);
   endfunction

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic s, input logic hold, output int lat);
      @(negedge clk);
      a8 = a; b8 = b; cin8 = c; sub8 = s; or8 = !hold; iv8 = 1'b1;
      @(posedge clk);
      #1 iv8 = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (ov8) break;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if ({ir8, ov8, s8, co8, of8, z8} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
         bad++;
         $display("FAIL reset8 got rdy=%b vld=%b sum=%h c=%b o=%b z=%b want rdy=1 vld=0 sum=00 flags=0",
                  ir8, ov8, s8, co8, of8, z8);
      end
      for (int j = 0; j < 3; j++) begin
         total++;
         if ({ir64[j], ovd64[j], s64[j], co64[j], of64[j], z64[j]} !== {2'b10, 64'd0, 3'b000}) begin
            bad++;
            $display("FAIL reset64[%0d] got rdy=%b vld=%b sum=%h want rdy=1 vld=0 sum=0",
                     j, ir64[j], ovd64[j], s64[j]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_add_wrap();
      int lat;
      drive8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, lat);
      total++;
      if ({lat, s8, co8, of8, z8} !== {32'd2, 8'h00, 3'b101}) begin
         bad++;
         $display("FAIL add_wrap got lat=%0d sum=%h c=%b o=%b z=%b want lat=2 sum=00 c=1 o=0 z=1",
                  lat, s8, co8, of8, z8);
      end
   endtask

   task automatic test_overflow();
      int lat;
      drive8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, lat);
      total++;
      if ({lat, s8, co8, of8, z8} !== {32'd2, 8'h80, 3'b010}) begin
         bad++;
         $display("FAIL ovf_pos got lat=%0d sum=%h c=%b o=%b z=%b want lat=2 sum=80 c=0 o=1 z=0",
                  lat, s8, co8, of8, z8);
      end
      drive8(8'h0A, 8'h05, 1'b1, 1'b0, 1'b0, lat);
      total++;
      if ({lat, s8, co8, of8, z8} !== {32'd2, 8'h10, 3'b000}) begin
         bad++;
         $display("FAIL carry_chunk got lat=%0d sum=%h c=%b o=%b z=%b want lat=2 sum=10 c=0 o=0 z=0",
                  lat, s8, co8, of8, z8);
      end
   endtask

   task automatic test_subtract();
      int lat;
      drive8(8'h05, 8'h07, 1'b1, 1'b1, 1'b0, lat);
      total++;
      if ({lat, s8, co8, of8, z8} !== {32'd2, 8'hFE, 3'b000}) begin
         bad++;
         $display("FAIL sub_borrow got lat=%0d sum=%h c=%b o=%b z=%b want lat=2 sum=fe c=0 o=0 z=0",
                  lat, s8, co8, of8, z8);
      end
      drive8(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, lat);
      total++;
      if ({lat, s8, co8, of8, z8} !== {32'd2, 8'h7F, 3'b110}) begin
         bad++;
         $display("FAIL sub_ovf got lat=%0d sum=%h c=%b o=%b z=%b want lat=2 sum=7f c=1 o=1 z=0",
                  lat, s8, co8, of8, z8);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      drive8(8'h3C, 8'h0F, 1'b1, 1'b0, 1'b1, lat);
      total++;
      if ({lat, s8, co8, of8, z8} !== {32'd2, 8'h4C, 3'b000}) begin
         bad++;
         $display("FAIL bp_result got lat=%0d sum=%h c=%b o=%b z=%b want lat=2 sum=4c flags=000",
                  lat, s8, co8, of8, z8);
      end
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin a8 = 8'h11; b8 = 8'h22; iv8 = 1'b1; end
         if (k == 2) iv8 = 1'b0;
         @(posedge clk);
         @(negedge clk);
         total++;
         if ({ov8, ir8, s8, co8, of8, z8} !== {2'b10, 8'h4C, 3'b000}) begin
            bad++;
            $display("FAIL bp_hold[%0d] got vld=%b rdy=%b sum=%h c=%b o=%b z=%b want vld=1 rdy=0 sum=4c",
                     k, ov8, ir8, s8, co8, of8, z8);
         end
      end
      or8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({ov8, ir8, s8} !== {2'b01, 8'h4C}) begin
         bad++;
         $display("FAIL bp_release got vld=%b rdy=%b sum=%h want vld=0 rdy=1 sum=4c", ov8, ir8, s8);
      end
   endtask

   task automatic test_reset_midop();
      int lat;
      @(negedge clk);
      a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b1; iv8 = 1'b1;
      @(posedge clk);
      #1 iv8 = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({ir8, ov8, s8, co8, of8, z8} !== {2'b10, 8'h00, 3'b000}) begin
         bad++;
         $display("FAIL reset_async got rdy=%b vld=%b sum=%h c=%b o=%b z=%b want rdy=1 vld=0 sum=00 flags=0",
                  ir8, ov8, s8, co8, of8, z8);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive8(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, lat);
      total++;
      if ({lat, s8, co8, of8, z8} !== {32'd2, 8'h02, 3'b000}) begin
         bad++;
         $display("FAIL after_reset got lat=%0d sum=%h c=%b o=%b z=%b want lat=2 sum=02 flags=000",
                  lat, s8, co8, of8, z8);
      end
   endtask

   task automatic test_sweep();
      logic [63:0] es;
      logic        ec, eo, ez;
      logic        seen [3];
      int          lat, k;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         k = 0;
         while (!(ir64[0] && ir64[1] && ir64[2]) && k < 200) begin
            @(negedge clk);
            k++;
         end
         a64   = {$urandom, $urandom};
         b64   = {$urandom, $urandom};
         if (n % 8 == 0) b64 = (n % 16 == 0) ? a64 : -a64;
         cin64 = 1'($urandom);
         sub64 = 1'($urandom);
         model(64, a64, b64, cin64, sub64, es, ec, eo, ez);
         iv64 = 1'b1;
         @(posedge clk);
         #1 iv64 = 1'b0;
         seen = '{1'b0, 1'b0, 1'b0};
         lat  = 0;
         while (!(seen[0] && seen[1] && seen[2]) && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
               if (!seen[j] && ovd64[j]) begin
                  seen[j] = 1'b1;
                  total++;
                  if ({lat, s64[j], co64[j], of64[j], z64[j]} !== {lat_exp[j], es, ec, eo, ez}) begin
                     bad++;
                     $display("FAIL sweep[%0d] chunk%0d a=%h b=%h cin=%b sub=%b got lat=%0d sum=%h c=%b o=%b z=%b want lat=%0d sum=%h c=%b o=%b z=%b",
                              n, j, a64, b64, cin64, sub64, lat, s64[j], co64[j], of64[j], z64[j],
                              lat_exp[j], es, ec, eo, ez);
                  end
               end
            end
         end
         for (int j = 0; j < 3; j++) begin
            if (!seen[j]) begin
               total++;
               bad++;
               $display("FAIL sweep_timeout[%0d] chunk%0d got no out_valid want latency %0d", n, j, lat_exp[j]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_overflow();
      test_subtract();
      test_backpressure();
      test_reset_midop();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
